elevator_request_scheduler: RTL

- Collects per-floor call requests into a pending vector and schedules them with SCAN (keep direction while calls remain ahead, else reverse).
- Drives target_floor and up_request/down_request into the elevator FSM controller, then tracks its move/door outputs to retire each serviced call.
- Sits between the call-button logic and the controller. The controller is the only consumer of target_floor and the request lines.

---
 rtl/elevator_pkg.sv | 17 +
 rtl/elevator_floor_select.sv | 32 +++
 rtl/elevator_request_scheduler.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared floor constants and state encodings for the elevator slice
package elevator_pkg;
    localparam int FLOOR_W    = 2;
    localparam int NUM_FLOORS = 1 << FLOOR_W;

    localparam logic [2:0] ST_IDLE        = 3'd0;
    localparam logic [2:0] ST_DISPATCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_ARRIVE = 3'd2;
    localparam logic [2:0] ST_SERVICE     = 3'd3;
    localparam logic [2:0] ST_HALT        = 3'd4;

    // Controller encoding, kept here so scheduler and controller benches agree.
    localparam logic [1:0] CTRL_IDLE        = 2'd0;
    localparam logic [1:0] CTRL_MOVING_UP   = 2'd1;
    localparam logic [1:0] CTRL_MOVING_DOWN = 2'd2;
    localparam logic [1:0] CTRL_DOOR_OPEN   = 2'd3;
endpackage

// File: rtl/elevator_floor_select.sv
// rtl/elevator_floor_select.sv - nearest pending floor above and below the car
module elevator_floor_select #(
    parameter int NUM_FLOORS = 4,
    parameter int FLOOR_W    = $clog2(NUM_FLOORS)
) (
    input  logic [NUM_FLOORS-1:0] pending,
    input  logic [FLOOR_W-1:0]    current_floor,
    output logic                  above_found,
    output logic [FLOOR_W-1:0]    above_floor,
    output logic                  below_found,
    output logic [FLOOR_W-1:0]    below_floor
);
    always_comb begin
        above_found = 1'b0;
        above_floor = '0;
        below_found = 1'b0;
        below_floor = '0;
        // Scan top-down so the last hit is the lowest floor above the car.
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (pending[i] && (FLOOR_W'(i) > current_floor)) begin
                above_found = 1'b1;
                above_floor = FLOOR_W'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (pending[i] && (FLOOR_W'(i) < current_floor)) begin
                below_found = 1'b1;
                below_floor = FLOOR_W'(i);
            end
        end
    end
endmodule

// File: rtl/elevator_request_scheduler.sv
// rtl/elevator_request_scheduler.sv - SCAN scheduler feeding target/request lines to the car controller
module elevator_request_scheduler #(
    parameter int NUM_FLOORS       = elevator_pkg::NUM_FLOORS,
    parameter int FLOOR_W          = elevator_pkg::FLOOR_W,
    parameter int DISPATCH_TIMEOUT = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] call_req,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  emergency_stop,
    input  logic                  move_up,
    input  logic                  move_down,
    input  logic                  door_open,
    output logic [FLOOR_W-1:0]    target_floor,
    output logic                  up_request,
    output logic                  down_request,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  dir_up,
    output logic                  served_valid,
    output logic [FLOOR_W-1:0]    served_floor,
    output logic                  dispatch_err,
    output logic                  busy
);
    import elevator_pkg::*;

    localparam int CNT_W = $clog2(DISPATCH_TIMEOUT + 1);

    logic [2:0]            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FLOOR_W-1:0]    target_q, target_d;
    logic                  up_q, up_d, down_q, down_d;
    logic [NUM_FLOORS-1:0] pending_q, pending_d, clr_mask;
    logic                  dir_q, dir_d;
    logic                  served_valid_q, served_valid_d;
    logic [FLOOR_W-1:0]    served_floor_q, served_floor_d;
    logic                  err_q, err_d;
    logic                  busy_q, busy_d;

    logic                  above_found, below_found;
    logic [FLOOR_W-1:0]    above_floor, below_floor;

    elevator_floor_select #(
        .NUM_FLOORS (NUM_FLOORS),
        .FLOOR_W    (FLOOR_W)
    ) u_floor_select (
        .pending       (pending_q),
        .current_floor (current_floor),
        .above_found   (above_found),
        .above_floor   (above_floor),
        .below_found   (below_found),
        .below_floor   (below_floor)
    );

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        target_d       = target_q;
        up_d           = up_q;
        down_d         = down_q;
        dir_d          = dir_q;
        served_valid_d = 1'b0;
        served_floor_d = served_floor_q;
        err_d          = 1'b0;
        clr_mask       = '0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                // The controller cannot travel to its own floor, so serve it here.
                if (pending_q[current_floor]) begin
                    clr_mask[current_floor] = 1'b1;
                    served_valid_d          = 1'b1;
                    served_floor_d          = current_floor;
                end else if (above_found && (dir_q || !below_found)) begin
                    target_d = above_floor;
                    dir_d    = 1'b1;
                    up_d     = 1'b1;
                    state_d  = ST_DISPATCH;
                end else if (below_found) begin
                    target_d = below_floor;
                    dir_d    = 1'b0;
                    down_d   = 1'b1;
                    state_d  = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                cnt_d = cnt_q + 1'b1;
                if ((up_q && move_up) || (down_q && move_down)) begin
                    up_d    = 1'b0;
                    down_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_WAIT_ARRIVE;
                end else if (cnt_d == CNT_W'(DISPATCH_TIMEOUT)) begin
                    up_d    = 1'b0;
                    down_d  = 1'b0;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT_ARRIVE: begin
                if (door_open && (current_floor == target_q)) begin
                    clr_mask[target_q] = 1'b1;
                    served_valid_d     = 1'b1;
                    served_floor_d     = target_q;
                    state_d            = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (!door_open) state_d = ST_IDLE;
            end
            ST_HALT: begin
                if (!emergency_stop) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Emergency overrides every state, including a serve decided above.
        if (emergency_stop) begin
            state_d        = ST_HALT;
            up_d           = 1'b0;
            down_d         = 1'b0;
            cnt_d          = '0;
            clr_mask       = '0;
            served_valid_d = 1'b0;
            served_floor_d = served_floor_q;
            err_d          = 1'b0;
        end

        // A clear on the same floor as a new press wins: that call is being served.
        pending_d = (pending_q | call_req) & ~clr_mask;
        busy_d    = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            cnt_q          <= '0;
            target_q       <= '0;
            up_q           <= 1'b0;
            down_q         <= 1'b0;
            pending_q      <= '0;
            dir_q          <= 1'b1;
            served_valid_q <= 1'b0;
            served_floor_q <= '0;
            err_q          <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            target_q       <= target_d;
            up_q           <= up_d;
            down_q         <= down_d;
            pending_q      <= pending_d;
            dir_q          <= dir_d;
            served_valid_q <= served_valid_d;
            served_floor_q <= served_floor_d;
            err_q          <= err_d;
            busy_q         <= busy_d;
        end
    end

    assign target_floor = target_q;
    assign up_request   = up_q;
    assign down_request = down_q;
    assign pending      = pending_q;
    assign dir_up       = dir_q;
    assign served_valid = served_valid_q;
    assign served_floor = served_floor_q;
    assign dispatch_err = err_q;
    assign busy         = busy_q;
endmodule
